tls_cmd_frontend: RTL and testbench

- Operator-command front end that sits directly upstream of the traffic-light controller and drives its Set, Stop, Jump, Gin, Yin and Rin inputs.
- Synchronises and debounces three raw push-buttons and converts presses into clean controller commands: a one-cycle Set pulse, a toggled Stop level and a one-cycle Jump pulse.
- Latches and validates the phase durations, and holds them stable before and during every Set pulse, because the controller samples them on the rising edge of Set.
- After reset it issues one automatic Set, because the controller's state register initialises only on Set.

---
 rtl/tls_cmd_frontend.sv | 136 +++++++++++++
 tb/tb_tls_cmd_frontend.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/tls_cmd_frontend.sv
// tls_cmd_frontend: operator-command front end for the traffic-light controller.
// Synchronises and debounces three raw buttons and turns presses into clean
// controller commands; latches and clamps the phase durations ahead of Set.
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   btn_set/stop/jump       raw asynchronous active-high buttons
//   cfg_g/cfg_y/cfg_r [3:0] requested green/yellow/red durations
//   Set                     one-cycle load pulse to the controller
//   Stop                    freeze level (toggled by stop presses)
//   Jump                    one-cycle skip-to-red pulse
//   Gin/Yin/Rin [3:0]       latched, zero-clamped durations
//   busy                    high during a load/Set sequence
module tls_cmd_frontend #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 16,
    parameter bit AUTO_SET   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_set,
    input  logic       btn_stop,
    input  logic       btn_jump,
    input  logic [3:0] cfg_g,
    input  logic [3:0] cfg_y,
    input  logic [3:0] cfg_r,
    output logic       Set,
    output logic       Stop,
    output logic       Jump,
    output logic [3:0] Gin,
    output logic [3:0] Yin,
    output logic [3:0] Rin,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, LOAD, PULSE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);

    state_t           state, state_n;
    logic [2:0]       btn, s1, s2, deb, deb_q, ev;
    logic [CNT_W-1:0] cnt [3];
    logic             auto_req;
    logic             set_n, stop_n, jump_n;
    logic [3:0]       gin_n, yin_n, rin_n;

    function automatic logic [3:0] clamp(input logic [3:0] v);
        return (v == 4'd0) ? 4'd1 : v;
    endfunction

    // Bit 0 = set, bit 1 = stop, bit 2 = jump throughout.
    assign btn  = {btn_jump, btn_stop, btn_set};
    assign ev   = deb & ~deb_q;
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1    <= '0;
            s2    <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            s1    <= btn;
            s2    <= s1;
            deb_q <= deb;
            for (int i = 0; i < 3; i++) begin
                if (s2[i] != deb[i]) begin
                    if (cnt[i] == LAST) begin
                        deb[i] <= s2[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    // Held high only through reset, so the automatic load fires on the
    // first cycle after reset releases.
    always_ff @(posedge clk) auto_req <= reset ? AUTO_SET : 1'b0;

    // Outputs are registered from the next state so that the durations and
    // the cleared Stop are visible during LOAD and Set is high during PULSE.
    always_comb begin
        state_n = state;
        set_n   = 1'b0;
        jump_n  = 1'b0;
        stop_n  = Stop;
        gin_n   = Gin;
        yin_n   = Yin;
        rin_n   = Rin;
        case (state)
            IDLE: begin
                if (ev[0] || auto_req) begin
                    // A set wins: stop/jump events in the same cycle are dropped.
                    state_n = LOAD;
                    stop_n  = 1'b0;
                    gin_n   = clamp(cfg_g);
                    yin_n   = clamp(cfg_y);
                    rin_n   = clamp(cfg_r);
                end else begin
                    jump_n = ev[2];
                    stop_n = Stop ^ ev[1];
                end
            end
            LOAD: begin
                state_n = PULSE;
                set_n   = 1'b1;
                stop_n  = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            Set   <= 1'b0;
            Stop  <= 1'b0;
            Jump  <= 1'b0;
            Gin   <= 4'd1;
            Yin   <= 4'd1;
            Rin   <= 4'd1;
        end else begin
            state <= state_n;
            Set   <= set_n;
            Stop  <= stop_n;
            Jump  <= jump_n;
            Gin   <= gin_n;
            Yin   <= yin_n;
            Rin   <= rin_n;
        end
    end
endmodule

// File: tb/tb_tls_cmd_frontend.sv
// tb_tls_cmd_frontend: self-checking bench for tls_cmd_frontend.
module tb_tls_cmd_frontend;
    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       reset, btn_set, btn_stop, btn_jump;
    logic [3:0] cfg_g, cfg_y, cfg_r;
    logic       Set, Stop, Jump, busy;
    logic [3:0] Gin, Yin, Rin;

    tls_cmd_frontend #(.DEB_CYCLES(DEB), .CNT_W(16), .AUTO_SET(1'b1)) dut (
        .clk(clk), .reset(reset), .btn_set(btn_set), .btn_stop(btn_stop), .btn_jump(btn_jump),
        .cfg_g(cfg_g), .cfg_y(cfg_y), .cfg_r(cfg_r), .Set(Set), .Stop(Stop), .Jump(Jump),
        .Gin(Gin), .Yin(Yin), .Rin(Rin), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Reference model: button levels pass through a two-sample delay, a
    // level is accepted once it has persisted DEB samples, and a sequence
    // is tracked as a countdown of remaining busy cycles.
    logic [2:0] m_s1, m_s2, m_deb, m_debp;
    int         m_run [3];
    int         m_left;
    logic       m_pend, m_set, m_stop, m_jump;
    logic [3:0] m_g, m_y, m_r;

    function automatic logic [3:0] cl(input logic [3:0] v);
        return v == 0 ? 4'd1 : v;
    endfunction

    task automatic model_step(input logic r, input logic [2:0] b, input logic [3:0] cg, cy, cr);
        logic [2:0] ev;
        ev = m_deb & ~m_debp;
        if (r) begin
            m_s1 = 0; m_s2 = 0; m_deb = 0; m_debp = 0;
            for (int i = 0; i < 3; i++) m_run[i] = 0;
            m_left = 0; m_pend = 1; m_set = 0; m_stop = 0; m_jump = 0;
            m_g = 1; m_y = 1; m_r = 1;
        end else begin
            m_debp = m_deb;
            for (int i = 0; i < 3; i++) begin
                m_run[i] = (m_s2[i] != m_deb[i]) ? m_run[i] + 1 : 0;
                if (m_run[i] == DEB) begin
                    m_deb[i] = m_s2[i];
                    m_run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = b;
            m_jump = 0;
            if (m_left == 0) begin
                if (ev[0] || m_pend) begin
                    m_left = 2;
                    m_stop = 0;
                    m_g = cl(cg); m_y = cl(cy); m_r = cl(cr);
                end else begin
                    m_jump = ev[2];
                    if (ev[1]) m_stop = !m_stop;
                end
            end else begin
                m_left--;
            end
            m_set  = (m_left == 1);
            m_pend = 0;
        end
    endtask

    task automatic tick();
        logic       r;
        logic [2:0] b;
        logic [3:0] cg, cy, cr;
        r = reset; b = {btn_jump, btn_stop, btn_set}; cg = cfg_g; cy = cfg_y; cr = cfg_r;
        @(posedge clk);
        model_step(r, b, cg, cy, cr);
        #1;
    endtask

    function automatic logic [15:0] dut_vec();
        return {Set, Stop, Jump, busy, Gin, Yin, Rin};
    endfunction

    typedef struct {
        logic       rst;
        logic [3:0] g, y, r;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl [12];

    int first, njump, nset, nstop_hi;
    bit found;
    int hold [3];

    initial begin
        reset = 1; btn_set = 0; btn_stop = 0; btn_jump = 0;
        cfg_g = 4'd5; cfg_y = 4'd2; cfg_r = 4'd7;
        // {Set,Stop,Jump,busy,Gin,Yin,Rin}
        tbl[0]  = '{1'b1, 4'd5, 4'd2, 4'd7,  16'h0111};
        tbl[1]  = '{1'b1, 4'd5, 4'd2, 4'd7,  16'h0111};
        tbl[2]  = '{1'b0, 4'd5, 4'd2, 4'd7,  16'h1527};
        tbl[3]  = '{1'b0, 4'd5, 4'd2, 4'd7,  16'h9527};
        tbl[4]  = '{1'b0, 4'd5, 4'd2, 4'd7,  16'h0527};
        tbl[5]  = '{1'b0, 4'd0, 4'd0, 4'd15, 16'h0527};
        tbl[6]  = '{1'b1, 4'd0, 4'd0, 4'd15, 16'h0111};
        tbl[7]  = '{1'b0, 4'd0, 4'd0, 4'd15, 16'h111F};
        tbl[8]  = '{1'b1, 4'd0, 4'd0, 4'd15, 16'h0111};
        tbl[9]  = '{1'b0, 4'd0, 4'd0, 4'd15, 16'h111F};
        tbl[10] = '{1'b0, 4'd0, 4'd0, 4'd15, 16'h911F};
        tbl[11] = '{1'b0, 4'd0, 4'd0, 4'd15, 16'h011F};
        for (int i = 0; i < 12; i++) begin
            reset = tbl[i].rst; cfg_g = tbl[i].g; cfg_y = tbl[i].y; cfg_r = tbl[i].r;
            tick();
            check($sformatf("table_row%0d", i), 32'(dut_vec()), 32'(tbl[i].exp));
        end

        // Short glitch on jump never produces a pulse.
        njump = 0;
        btn_jump = 1;
        repeat (3) begin tick(); njump += int'(Jump); end
        btn_jump = 0;
        repeat (12) begin tick(); njump += int'(Jump); end
        check("jump_glitch", njump, 0);

        // Held jump: one pulse, visible after edge k+6.
        first = -1; njump = 0;
        btn_jump = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (Jump) begin njump++; if (first < 0) first = i; end
        end
        check("jump_first_edge", first, 6);
        check("jump_count_held", njump, 1);
        btn_jump = 0;
        repeat (12) begin tick(); njump += int'(Jump); end
        check("jump_no_release_pulse", njump, 1);
        btn_jump = 1;
        repeat (12) begin tick(); njump += int'(Jump); end
        btn_jump = 0;
        repeat (12) tick();
        check("jump_repress", njump, 2);

        // Stop toggles on each press.
        btn_stop = 1; repeat (10) tick(); btn_stop = 0; repeat (10) tick();
        check("stop_first", 32'(Stop), 1);
        btn_stop = 1; repeat (10) tick(); btn_stop = 0; repeat (10) tick();
        check("stop_second", 32'(Stop), 0);
        btn_stop = 1; repeat (10) tick(); btn_stop = 0; repeat (10) tick();
        check("stop_third", 32'(Stop), 1);
        cfg_g = 4'd3; cfg_y = 4'd4; cfg_r = 4'd9;
        btn_set = 1; found = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (!found && busy) begin
                found = 1;
                check("stop_cleared_in_load", 32'(Stop), 0);
                check("load_durations", 32'({Gin, Yin, Rin}), 32'(12'h349));
            end
        end
        check("set_seen", 32'(found), 1);
        btn_set = 0; repeat (12) tick();

        // Set and jump together: set wins.
        njump = 0; nset = 0;
        btn_set = 1; btn_jump = 1;
        repeat (15) begin tick(); njump += int'(Jump); nset += int'(Set); end
        btn_set = 0; btn_jump = 0;
        repeat (12) begin tick(); njump += int'(Jump); end
        check("setjump_no_jump", njump, 0);
        check("setjump_one_set", nset, 1);

        // Jump debouncing into PULSE is dropped.
        njump = 0; nset = 0;
        btn_set = 1; tick(); tick(); btn_jump = 1;
        repeat (15) begin tick(); njump += int'(Jump); nset += int'(Set); end
        btn_set = 0; btn_jump = 0;
        repeat (12) tick();
        check("jump_in_pulse_dropped", njump, 0);
        check("jump_in_pulse_set", nset, 1);

        // Clamp via a button press, then cfg changes are ignored.
        cfg_g = 0; cfg_y = 0; cfg_r = 15;
        btn_set = 1; repeat (10) tick(); btn_set = 0; repeat (10) tick();
        check("clamp", 32'({Gin, Yin, Rin}), 32'(12'h11F));
        cfg_g = 6; cfg_y = 7; cfg_r = 8;
        repeat (5) tick();
        check("cfg_ignored", 32'({Gin, Yin, Rin}), 32'(12'h11F));

        // Randomised run against the model.
        reset = 1; tick(); tick();
        reset = 0;
        for (int i = 0; i < 3; i++) hold[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (hold[i] == 0) begin
                    hold[i] = $urandom_range(1, 12);
                    case (i)
                        0: btn_set  = 1'($urandom_range(0, 1));
                        1: btn_stop = 1'($urandom_range(0, 1));
                        default: btn_jump = 1'($urandom_range(0, 1));
                    endcase
                end
                hold[i]--;
            end
            cfg_g = 4'($urandom_range(0, 15));
            cfg_y = 4'($urandom_range(0, 15));
            cfg_r = 4'($urandom_range(0, 15));
            reset = ($urandom_range(0, 299) == 0);
            tick();
            check("random", 32'(dut_vec()),
                  32'({m_set, m_stop, m_jump, 1'(m_left != 0), m_g, m_y, m_r}));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
